dmem_rmw_ctrl: RTL

Memory-side responder for the CPU data-memory port. It accepts one load or store request at a time from the MEM stage using a valid/ready handshake, and drives a single-port, word-wide synchronous RAM. Sub-word stores are done as a read-modify-write sequence. Loads return data that is already aligned and sign- or zero-extended, together with an error flag for illegal, misaligned or out-of-range accesses.

---
 rtl/dmem_pkg.sv | 53 +++++
 rtl/dmem_lane_align.sv | 64 ++++++
 rtl/dmem_rmw_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory read-modify-write responder:
// access codes, FSM state constants and the request legality check.
package dmem_pkg;

  // Access codes presented on req_access
  localparam logic [3:0] ACC_LW  = 4'b0000;
  localparam logic [3:0] ACC_LH  = 4'b0001;
  localparam logic [3:0] ACC_LB  = 4'b0010;
  localparam logic [3:0] ACC_LBU = 4'b0011;
  localparam logic [3:0] ACC_LHU = 4'b0100;
  localparam logic [3:0] ACC_SW  = 4'b1000;
  localparam logic [3:0] ACC_SH  = 4'b1001;
  localparam logic [3:0] ACC_SB  = 4'b1011;

  // Controller states
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  function automatic logic acc_known(input logic [3:0] acc);
    case (acc)
      ACC_LW, ACC_LH, ACC_LB, ACC_LBU, ACC_LHU,
      ACC_SW, ACC_SH, ACC_SB: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic acc_is_store(input logic [3:0] acc);
    return (acc == ACC_SW) || (acc == ACC_SH) || (acc == ACC_SB);
  endfunction

  function automatic logic acc_is_word(input logic [3:0] acc);
    return (acc == ACC_LW) || (acc == ACC_SW);
  endfunction

  function automatic logic acc_is_half(input logic [3:0] acc);
    return (acc == ACC_LH) || (acc == ACC_LHU) || (acc == ACC_SH);
  endfunction

  // A request is rejected for an unknown code, an address beyond the RAM,
  // a misaligned word, or a halfword that would straddle the word boundary.
  function automatic logic access_err(input logic [3:0] acc,
                                      input logic [1:0] off,
                                      input logic       addr_hi_nz);
    return !acc_known(acc)
        || addr_hi_nz
        || (acc_is_word(acc) && (off != 2'd0))
        || (acc_is_half(acc) && (off == 2'd3));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte or
// halfword from a read word, and merges store data into that word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [3:0]  acc,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] wr_word
);

  logic        [4:0]  sh;
  logic        [7:0]  byte_lane;
  logic        [15:0] half_lane;
  logic signed [31:0] byte_sext;
  logic signed [31:0] half_sext;
  logic        [31:0] lane_mask;
  logic        [31:0] wdata_sh;

  assign sh = {off, 3'b000};

  // Select the byte and halfword lanes addressed by the offset
  always_comb begin
    byte_lane = rword[7:0];
    half_lane = rword[15:0];
    case (off)
      2'd0: begin byte_lane = rword[7:0];   half_lane = rword[15:0];  end
      2'd1: begin byte_lane = rword[15:8];  half_lane = rword[23:8];  end
      2'd2: begin byte_lane = rword[23:16]; half_lane = rword[31:16]; end
      default: begin byte_lane = rword[31:24]; half_lane = rword[31:16]; end
    endcase
  end

  assign byte_sext = signed'({{24{byte_lane[7]}}, byte_lane});
  assign half_sext = signed'({{16{half_lane[15]}}, half_lane});

  // Extend the selected lane according to the load type
  always_comb begin
    ld_data = 32'd0;
    case (acc)
      ACC_LW:  ld_data = rword;
      ACC_LH:  ld_data = unsigned'(half_sext);
      ACC_LHU: ld_data = {16'd0, half_lane};
      ACC_LB:  ld_data = unsigned'(byte_sext);
      ACC_LBU: ld_data = {24'd0, byte_lane};
      default: ld_data = 32'd0;
    endcase
  end

  // Build the store lane mask; bytes outside it keep the read value
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    if (acc_is_half(acc))
      lane_mask = 32'h0000_FFFF << sh;
    else if (acc == ACC_SB)
      lane_mask = 32'h0000_00FF << sh;
  end

  assign wdata_sh = wdata << sh;
  assign wr_word  = (rword & ~lane_mask) | (wdata_sh & lane_mask);

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory responder: one load/store at a time over valid/ready,
// single-port synchronous RAM, sub-word stores via read-modify-write.
module dmem_rmw_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_access,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [2:0]  state;
  logic [3:0]  acc_p0;
  logic [1:0]  off_p0;
  logic [31:0] wdata_p0;
  logic        addr_hi_nz;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] wr_word;

  // RAM strobes are decoded from state so a reset drops them at once,
  // suppressing a write that has not yet been clocked.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_en     = (state == READ) || (state == WRITE);
  assign mem_we     = (state == WRITE);

  assign addr_hi_nz = |req_addr[31:ADDR_W+2];
  assign req_err    = access_err(req_access, req_addr[1:0], addr_hi_nz);

  dmem_lane_align u_lane (
    .off     (off_p0),
    .acc     (acc_p0),
    .rword   (mem_rdata),
    .wdata   (wdata_p0),
    .ld_data (ld_data),
    .wr_word (wr_word)
  );

  // Request latching, FSM sequencing and RAM/response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc_p0     <= 4'd0;
      off_p0     <= 2'd0;
      wdata_p0   <= 32'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        // Stage p0: accept and latch the request
        IDLE: begin
          if (req_valid) begin
            acc_p0     <= req_access;
            off_p0     <= req_addr[1:0];
            wdata_p0   <= req_wdata;
            mem_addr   <= req_addr[ADDR_W+1:2];
            resp_rdata <= 32'd0;
            resp_err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else if (req_access == ACC_SW) begin
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ:  state <= WAIT;
        // Stage p1: read word is on mem_rdata; extract or merge
        WAIT: begin
          if (acc_is_store(acc_p0)) begin
            mem_wdata <= wr_word;
            state     <= WRITE;
          end else begin
            resp_rdata <= ld_data;
            state      <= RESP;
          end
        end
        WRITE: state <= RESP;
        // Stage p2: hold the response until it is taken
        RESP: begin
          if (resp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
